secu_access_ctrl: RTL and testbench

- Sequential access controller around the 4-bit security code comparator (stored code s vs entered code p -> go/stop).
- Latches keypad entries, runs the compare, and holds go for a grant window or stop for a deny pulse.
- Counts consecutive failures and enforces a timed lockout.
- Sits between the keypad front end and the door/actuator drivers; stored code is reprogrammable only while access is granted.

---
 rtl/secu_pkg.sv | 25 ++
 rtl/secu_access_ctrl_if.sv | 45 ++++
 rtl/secu_cmp.sv | 18 +
 rtl/secu_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_secu_access_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/secu_pkg.sv
// Shared types and helpers for the security access controller.
//   state_e   : controller FSM states
//   CodeWDefault : default width of stored/entered codes
//   timer_w() : width of the grant/lockout down-counter
package secu_pkg;

  localparam int unsigned CodeWDefault = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StGrant,
    StDeny,
    StLockout
  } state_e;

  // Enough bits to hold max(grant_cyc, lock_cyc) - 1, never less than one bit.
  function automatic int unsigned timer_w(input int unsigned grant_cyc,
                                          input int unsigned lock_cyc);
    int unsigned mx;
    mx = (grant_cyc > lock_cyc) ? grant_cyc : lock_cyc;
    return (mx > 1) ? $clog2(mx) : 1;
  endfunction

endpackage

// File: rtl/secu_access_ctrl_if.sv
// Keypad / actuator bundle of the security access controller.
//   code_in, code_vld     : entered code and its one-cycle strobe
//   prog_vld, prog_code   : stored-code write request (honoured only while granted)
//   admin_clr             : admin clear, present only with SECU_ADMIN_CLR_EN defined
//   go, stop, locked, busy, tries_left : registered status back to the drivers
// master = keypad side, slave = controller.
interface secu_access_ctrl_if
  import secu_pkg::*;
#(
  parameter int unsigned CODE_W    = CodeWDefault,
  parameter int unsigned MAX_TRIES = 3
);

  localparam int unsigned CntW = $clog2(MAX_TRIES + 1);

  logic [CODE_W-1:0] code_in;
  logic              code_vld;
  logic              prog_vld;
  logic [CODE_W-1:0] prog_code;
`ifdef SECU_ADMIN_CLR_EN
  logic              admin_clr;
`endif
  logic              go;
  logic              stop;
  logic              locked;
  logic              busy;
  logic [CntW-1:0]   tries_left;

  modport master (
`ifdef SECU_ADMIN_CLR_EN
    output admin_clr,
`endif
    output code_in, code_vld, prog_vld, prog_code,
    input  go, stop, locked, busy, tries_left
  );

  modport slave (
`ifdef SECU_ADMIN_CLR_EN
    input  admin_clr,
`endif
    input  code_in, code_vld, prog_vld, prog_code,
    output go, stop, locked, busy, tries_left
  );

endinterface

// File: rtl/secu_cmp.sv
// Combinational security code comparator.
//   s    : stored code
//   p    : entered code
//   go   : codes match
//   stop : codes differ
module secu_cmp #(
  parameter int unsigned CODE_W = 4
) (
  input  logic [CODE_W-1:0] s,
  input  logic [CODE_W-1:0] p,
  output logic              go,
  output logic              stop
);

  assign go   = (s == p);
  assign stop = ~go;

endmodule

// File: rtl/secu_access_ctrl.sv
// Sequential access controller: latches keypad entries, compares them against the
// stored code, holds go for a grant window or stop for a deny pulse, counts
// consecutive failures and enforces a timed lockout. The stored code can only be
// rewritten while access is granted.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : secu_access_ctrl_if.slave (entry, programming and status signals)
// Optional: define SECU_ADMIN_CLR_EN to add bus.admin_clr, which aborts DENY or
// LOCKOUT and clears the failure count.
module secu_access_ctrl
  import secu_pkg::*;
#(
  parameter int unsigned       CODE_W     = CodeWDefault,
  parameter int unsigned       MAX_TRIES  = 3,
  parameter int unsigned       GRANT_CYC  = 8,
  parameter int unsigned       LOCK_CYC   = 16,
  parameter logic [CODE_W-1:0] RESET_CODE = '0
) (
  input logic              clk,
  input logic              rst,
  secu_access_ctrl_if.slave bus
);

  localparam int unsigned CntW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TimerW = timer_w(GRANT_CYC, LOCK_CYC);

  localparam logic [CntW-1:0]   FailMax   = CntW'(MAX_TRIES);
  localparam logic [CntW-1:0]   FailLast  = CntW'(MAX_TRIES - 1);
  localparam logic [TimerW-1:0] GrantLoad = TimerW'(GRANT_CYC - 1);
  localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCK_CYC - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   p_q, p_d;
  logic [CntW-1:0]     fail_cnt_q, fail_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                go_q, stop_q, locked_q, busy_q;
  logic                cmp_go, cmp_stop;
  logic                admin_clr;

`ifdef SECU_ADMIN_CLR_EN
  assign admin_clr = bus.admin_clr;
`else
  assign admin_clr = 1'b0;
`endif

  secu_cmp #(
    .CODE_W (CODE_W)
  ) u_cmp (
    .s    (code_q),
    .p    (p_q),
    .go   (cmp_go),
    .stop (cmp_stop)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    p_d        = p_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;

    unique case (state_q)
      StIdle: begin
        if (bus.code_vld) begin
          p_d     = bus.code_in;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (cmp_go) begin
          fail_cnt_d = '0;
          timer_d    = GrantLoad;
          state_d    = StGrant;
        end else if (cmp_stop) begin
          // >= keeps the counter saturated even if it were somehow already full.
          if (fail_cnt_q >= FailLast) begin
            fail_cnt_d = FailMax;
            timer_d    = LockLoad;
            state_d    = StLockout;
          end else begin
            fail_cnt_d = fail_cnt_q + 1'b1;
            state_d    = StDeny;
          end
        end
      end
      StGrant: begin
        if (bus.prog_vld) begin
          code_d = bus.prog_code;
        end
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDeny: begin
        state_d = StIdle;
      end
      StLockout: begin
        if (timer_q == '0) begin
          fail_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Admin clear overrides timer expiry; outside DENY/LOCKOUT it only resets the count.
    if (admin_clr) begin
      fail_cnt_d = '0;
      if (state_q == StDeny || state_q == StLockout) begin
        state_d = StIdle;
        timer_d = '0;
      end
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      code_q     <= RESET_CODE;
      p_q        <= '0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      go_q       <= 1'b0;
      stop_q     <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      p_q        <= p_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      go_q       <= (state_d == StGrant);
      stop_q     <= (state_d == StDeny) || (state_d == StLockout);
      locked_q   <= (state_d == StLockout);
      busy_q     <= (state_d != StIdle);
    end
  end

  assign bus.go         = go_q;
  assign bus.stop       = stop_q;
  assign bus.locked     = locked_q;
  assign bus.busy       = busy_q;
  assign bus.tries_left = FailMax - fail_cnt_q;

endmodule

// File: tb/tb_secu_access_ctrl.sv
// Directed bench for secu_access_ctrl (CODE_W=4, MAX_TRIES=3, GRANT_CYC=8, LOCK_CYC=16).
// Inputs are driven and outputs sampled on the falling edge.
module tb_secu_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  secu_access_ctrl_if #(
    .CODE_W    (4),
    .MAX_TRIES (3)
  ) bus ();

  secu_access_ctrl #(
    .CODE_W     (4),
    .MAX_TRIES  (3),
    .GRANT_CYC  (8),
    .LOCK_CYC   (16),
    .RESET_CODE (4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic go, input logic stop,
                             input logic locked, input logic busy, input int unsigned tries);
    check_eq({tag, "/go"},     32'(bus.go),         32'(go));
    check_eq({tag, "/stop"},   32'(bus.stop),       32'(stop));
    check_eq({tag, "/locked"}, 32'(bus.locked),     32'(locked));
    check_eq({tag, "/busy"},   32'(bus.busy),       32'(busy));
    check_eq({tag, "/tries"},  32'(bus.tries_left), tries);
  endtask

  // One-cycle entry strobe; returns at the falling edge of the CHECK cycle.
  task automatic enter(input logic [3:0] c);
    bus.code_in  = c;
    bus.code_vld = 1'b1;
    @(negedge clk);
    bus.code_vld = 1'b0;
  endtask

  // Three wrong entries; returns at the falling edge of the CHECK that locks out.
  task automatic drive_to_lockout();
    enter(4'b0101);
    @(negedge clk);
    @(negedge clk);
    enter(4'b0101);
    @(negedge clk);
    @(negedge clk);
    enter(4'b0101);
  endtask

  initial begin
    bus.code_in   = '0;
    bus.code_vld  = 1'b0;
    bus.prog_vld  = 1'b0;
    bus.prog_code = '0;
`ifdef SECU_ADMIN_CLR_EN
    bus.admin_clr = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    expect_outs("reset", 0, 0, 0, 0, 3);
    rst = 1'b0;
    @(negedge clk);
    expect_outs("idle0", 0, 0, 0, 0, 3);

    // Correct default code: go for exactly 8 cycles starting two after the strobe
    enter(4'b0000);
    expect_outs("check", 0, 0, 0, 1, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expect_outs("grant", 1, 0, 0, 1, 3);
    end
    @(negedge clk);
    expect_outs("grant_end", 0, 0, 0, 0, 3);

    // Two wrong entries: one-cycle stop each, tries 2 then 1
    enter(4'b0101);
    @(negedge clk);
    expect_outs("deny1", 0, 1, 0, 1, 2);
    @(negedge clk);
    expect_outs("deny1_end", 0, 0, 0, 0, 2);
    enter(4'b0101);
    @(negedge clk);
    expect_outs("deny2", 0, 1, 0, 1, 1);
    @(negedge clk);
    expect_outs("deny2_end", 0, 0, 0, 0, 1);

    // Third wrong entry: 16-cycle lockout, correct code entered meanwhile is dropped
    enter(4'b0101);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expect_outs("lock", 0, 1, 1, 1, 0);
      if (i == 3) begin
        bus.code_in  = 4'b0000;
        bus.code_vld = 1'b1;
      end else begin
        bus.code_vld = 1'b0;
      end
    end
    @(negedge clk);
    expect_outs("lock_end", 0, 0, 0, 0, 3);
    @(negedge clk);
    expect_outs("lock_drop", 0, 0, 0, 0, 3);

    // Reprogram during GRANT
    enter(4'b0000);
    @(negedge clk);
    expect_outs("prog_grant", 1, 0, 0, 1, 3);
    bus.prog_code = 4'b1010;
    bus.prog_vld  = 1'b1;
    @(negedge clk);
    expect_outs("prog_grant2", 1, 0, 0, 1, 3);
    bus.prog_vld = 1'b0;
    repeat (7) @(negedge clk);
    expect_outs("prog_end", 0, 0, 0, 0, 3);
    enter(4'b0000);
    @(negedge clk);
    expect_outs("old_code", 0, 1, 0, 1, 2);
    @(negedge clk);
    enter(4'b1010);
    @(negedge clk);
    expect_outs("new_code", 1, 0, 0, 1, 3);

    // Async reset mid-GRANT
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    expect_outs("rst_grant", 0, 0, 0, 0, 3);
    @(negedge clk);
    rst = 1'b0;
    enter(4'b0000);
    @(negedge clk);
    expect_outs("rst_code", 1, 0, 0, 1, 3);
    repeat (8) @(negedge clk);
    expect_outs("rst_code_end", 0, 0, 0, 0, 3);

    // Async reset mid-LOCKOUT
    drive_to_lockout();
    repeat (5) @(negedge clk);
    expect_outs("lock_mid", 0, 1, 1, 1, 0);
    rst = 1'b1;
    #1;
    expect_outs("rst_lock", 0, 0, 0, 0, 3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_outs("rst_lock_idle", 0, 0, 0, 0, 3);
    enter(4'b0000);
    @(negedge clk);
    expect_outs("rst_lock_grant", 1, 0, 0, 1, 3);
    repeat (8) @(negedge clk);
    expect_outs("rst_lock_end", 0, 0, 0, 0, 3);

`ifdef SECU_ADMIN_CLR_EN
    // Admin clear three cycles into LOCKOUT
    drive_to_lockout();
    repeat (3) @(negedge clk);
    expect_outs("adm_lock", 0, 1, 1, 1, 0);
    bus.admin_clr = 1'b1;
    @(negedge clk);
    bus.admin_clr = 1'b0;
    expect_outs("adm_clr", 0, 0, 0, 0, 3);
    enter(4'b0000);
    @(negedge clk);
    expect_outs("adm_grant", 1, 0, 0, 1, 3);
    repeat (8) @(negedge clk);
    expect_outs("adm_end", 0, 0, 0, 0, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
